// File: rtl/exmem_pkg.sv
// Shared definitions for the EX->MEM stage: control-word bit map and entry width.
// The control word is packed {mem_val, mem_rw, reg_we, wb_sel}.
package exmem_pkg;

    localparam int CTRL_WB_SEL  = 0;
    localparam int CTRL_REG_WE  = 1;
    localparam int CTRL_MEM_RW  = 2;
    localparam int CTRL_MEM_VAL = 3;

    localparam int CTRL_W_DEF = 4;
    localparam int XLEN_DEF   = 32;
    localparam int RD_W_DEF   = 5;

    // Packed entry layout is {alu_out, rs2, rd, ctrl}.
    function automatic int entry_w(input int xlen, input int rd_w, input int ctrl_w);
        return 2 * xlen + rd_w + ctrl_w;
    endfunction

    localparam int ENTRY_W_DEF = entry_w(XLEN_DEF, RD_W_DEF, CTRL_W_DEF);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with flush. Define EXMEM_SKID_EN for a two-entry
// skid (registered in_ready); otherwise a single entry with combinational in_ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_reg, main_valid_next;
    logic [W-1:0] main_data_reg, main_data_next;
    logic         push;
    logic         pop;

`ifdef EXMEM_SKID_EN
    logic         spare_valid_reg, spare_valid_next;
    logic [W-1:0] spare_data_reg, spare_data_next;

    // in_ready comes straight from a flop, breaking the out_ready->in_ready path.
    assign in_ready = !spare_valid_reg;
    assign push     = in_valid && in_ready;
    assign pop      = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next  = main_valid_reg;
        main_data_next   = main_data_reg;
        spare_valid_next = spare_valid_reg;
        spare_data_next  = spare_data_reg;
        if (flush) begin
            main_valid_next  = 1'b0;
            spare_valid_next = 1'b0;
        end else if (spare_valid_reg) begin
            if (pop) begin
                main_data_next   = spare_data_reg;
                spare_valid_next = 1'b0;
            end
        end else if (push && main_valid_reg && !out_ready) begin
            spare_valid_next = 1'b1;
            spare_data_next  = in_data;
        end else if (push) begin
            main_valid_next = 1'b1;
            main_data_next  = in_data;
        end else if (pop) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg  <= 1'b0;
            main_data_reg   <= '0;
            spare_valid_reg <= 1'b0;
            spare_data_reg  <= '0;
        end else begin
            main_valid_reg  <= main_valid_next;
            main_data_reg   <= main_data_next;
            spare_valid_reg <= spare_valid_next;
            spare_data_reg  <= spare_data_next;
        end
    end
`else
    assign in_ready = !main_valid_reg || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        if (flush) begin
            main_valid_next = 1'b0;
        end else if (push) begin
            main_valid_next = 1'b1;
            main_data_next  = in_data;
        end else if (pop) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
        end
    end
`endif

    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM valid/ready pipeline stage with bubble masking, forwarding tap and stall counter.
// Define EXMEM_SKID_EN to build the two-entry skid variant of the underlying buffer.
module ex_mem_stage
    import exmem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu_out,
    output logic [XLEN-1:0]   out_rs2,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [SCNT_W-1:0] stall_cnt
);

    localparam int EW = entry_w(XLEN, RD_W, CTRL_W);

    logic [EW-1:0]     in_word;
    logic [EW-1:0]     buf_word;
    logic              buf_valid;
    logic [CTRL_W-1:0] buf_ctrl;
    logic [SCNT_W-1:0] stall_cnt_reg;

    assign in_word = {in_alu_out, in_rs2, in_rd, in_ctrl};

    pipe_skid_buf #(.W(EW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_word),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (buf_word)
    );

    assign {out_alu_out, out_rs2, out_rd, buf_ctrl} = buf_word;
    assign out_valid = buf_valid;

    // A bubble must never carry reg_we or mem_val downstream.
    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = buf_ctrl[gi] & buf_valid;
        end
    endgenerate

    assign fwd_valid = buf_valid && buf_ctrl[CTRL_REG_WE] && (out_rd != '0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (buf_valid && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + {{(SCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios followed by randomized traffic,
// checked against a queue model of accepted-but-unconsumed entries.
module tb_ex_mem_stage;

    localparam int XLEN   = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 4;
    localparam int SCNT_W = 4;
    localparam int CNT_MAX = (1 << SCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   in_alu_out = '0;
    logic [XLEN-1:0]   in_rs2 = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_alu_out;
    logic [XLEN-1:0]   out_rs2;
    logic [RD_W-1:0]   out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic [SCNT_W-1:0] stall_cnt;

    ex_mem_stage #(
        .XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W), .SCNT_W(SCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_out (in_alu_out),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_out(out_alu_out),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_ctrl   (out_ctrl),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    ent_t exp_q[$];
    int   cnt_m    = 0;
    bit   model_ok = 1'b0;
    bit   rdy_m    = 1'b0;
    int   n_chk    = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy rule: single entry accepts when empty or draining; skid accepts while a slot is free.
    function automatic bit pred_rdy();
`ifdef EXMEM_SKID_EN
        return exp_q.size() < 2;
`else
        return (exp_q.size() == 0) || out_ready;
`endif
    endfunction

    // Stimulus side: record every accepted instruction as an expected MEM-side entry.
    always @(posedge clk) begin : tracker
        ent_t e;
        if (model_ok && !rst && !flush && in_valid && rdy_m) begin
            e.alu  = in_alu_out;
            e.rs2  = in_rs2;
            e.rd   = in_rd;
            e.ctrl = in_ctrl;
            exp_q.push_back(e);
            $display("push alu=%08h rs2=%08h rd=%0d ctrl=%h", e.alu, e.rs2, e.rd, e.ctrl);
        end
    end

    // Monitor: compare the presented entry against the queue head, then retire it on a handshake.
    always @(negedge clk) begin : monitor
        ent_t h;
        if (model_ok) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, pred_rdy()});
            chk("stall_cnt", {28'b0, stall_cnt}, cnt_m);
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                chk("out_alu_out", out_alu_out, h.alu);
                chk("out_rs2", out_rs2, h.rs2);
                chk("out_rd", {27'b0, out_rd}, {27'b0, h.rd});
                chk("out_ctrl", {28'b0, out_ctrl}, {28'b0, h.ctrl});
                chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, h.ctrl[1] && (h.rd != 0)});
                chk("fwd_rd", {27'b0, fwd_rd}, {27'b0, h.rd});
                chk("fwd_data", fwd_data, h.alu);
            end else begin
                chk("bubble_ctrl", {28'b0, out_ctrl}, 32'h0);
                chk("bubble_fwd", {31'b0, fwd_valid}, 32'h0);
            end
        end
        rdy_m = pred_rdy();
        if (rst) begin
            exp_q.delete();
            cnt_m    = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (exp_q.size() > 0 && !out_ready && cnt_m < CNT_MAX) cnt_m++;
            if (flush) begin
                exp_q.delete();
            end else if (exp_q.size() > 0 && out_ready) begin
                h = exp_q.pop_front();
                $display("pop  alu=%08h rs2=%08h rd=%0d ctrl=%h", h.alu, h.rs2, h.rd, h.ctrl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2,
                         input logic [RD_W-1:0] rd, input logic [CTRL_W-1:0] ctrl);
        in_valid   = 1'b1;
        in_alu_out = alu;
        in_rs2     = rs2;
        in_rd      = rd;
        in_ctrl    = ctrl;
    endtask

    task automatic drive_rand();
        drive($urandom, $urandom, RD_W'($urandom_range(0, 31)), CTRL_W'($urandom_range(0, 15)));
    endtask

    initial begin
        // T1: reset for three cycles
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("t1_in_ready", {31'b0, in_ready}, 32'h1);
        chk("t1_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t1_alu", out_alu_out, 32'h0);
        chk("t1_rs2", out_rs2, 32'h0);
        chk("t1_rd", {27'b0, out_rd}, 32'h0);
        chk("t1_ctrl", {28'b0, out_ctrl}, 32'h0);
        chk("t1_stall_cnt", {28'b0, stall_cnt}, 32'h0);
        chk("t1_fwd_valid", {31'b0, fwd_valid}, 32'h0);

        // T2: back-to-back transfers
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h10 + 32'(i), $urandom, RD_W'(i + 1), 4'h2);
            step();
            chk("t2_alu", out_alu_out, 32'h10 + 32'(i));
        end
        in_valid = 1'b0;
        repeat (2) step();

        // T3: five-cycle MEM stall
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(32'hDEADBEEF, 32'h0BADF00D, 5'd3, 4'hA);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("t3_stall_cnt", {28'b0, stall_cnt}, 32'h5);
        chk("t3_alu_held", out_alu_out, 32'hDEADBEEF);
        chk("t3_ctrl_held", {28'b0, out_ctrl}, 32'hA);
        out_ready = 1'b1;
        step();
        chk("t3_popped", {31'b0, out_valid}, 32'h0);
        chk("t3_cnt_kept", {28'b0, stall_cnt}, 32'h5);

        // T4: flush with a held entry and an incoming one
        drive(32'h12345678, 32'h1, 5'd9, 4'hF);
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        drive(32'hBAD0BAD0, 32'h2, 5'd10, 4'hF);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t4_out_ctrl", {28'b0, out_ctrl}, 32'h0);
        chk("t4_fwd_valid", {31'b0, fwd_valid}, 32'h0);
        chk("t4_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        repeat (3) step();

        // T5: forwarding tap
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(32'h33, 32'h0, 5'd0, 4'b0010);
        step();
        chk("t5_fwd_rd0", {31'b0, fwd_valid}, 32'h0);
        drive(32'h55, 32'h0, 5'd7, 4'b0010);
        step();
        chk("t5_fwd_valid", {31'b0, fwd_valid}, 32'h1);
        chk("t5_fwd_rd", {27'b0, fwd_rd}, 32'h7);
        chk("t5_fwd_data", fwd_data, 32'h55);
        in_valid = 1'b0;
        step();

        // T6: counter saturation, then randomized traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_rand();
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("t6_saturate", {28'b0, stall_cnt}, 32'hF);
        out_ready = 1'b1;
        step();

        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7) drive_rand();
            else in_valid = 1'b0;
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("t6_drained", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
